// File: rtl/snn_run_controller.sv
// snn_run_controller: run sequencer between the AXI-Lite register file and the neuron array.
// Decodes the software control/config words. Sequences N timesteps of programmable length.
// Issues timestep ticks and neuron resets. Counts output spikes for readback.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   ctrl_reg       [0] enable, [1] soft_reset, [2] start (rising edge), [3] clear_count (rising edge)
//   config_reg     [15:0] num_timesteps, [31:16] cycles_per_timestep (0 behaves as 1)
//   spike_valid    one output spike from the array this cycle
//   array_busy     array still processing in-flight events
//   timestep_tick  one-cycle pulse in the last cycle of each timestep
//   neuron_reset   clears neuron state in the array (start pulse, or held during soft reset)
//   done_pulse     one-cycle run-completion pulse
//   status_reg     {ts_idx, 8'h0, 2'b0, state, error, aborted, done, busy}
//   spike_count    saturating spike count since the last clear
module snn_run_controller #(
  parameter int unsigned TS_WIDTH  = 16,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          ctrl_reg,
  input  logic [31:0]          config_reg,
  input  logic                 spike_valid,
  input  logic                 array_busy,
  output logic                 timestep_tick,
  output logic                 neuron_reset,
  output logic                 done_pulse,
  output logic [31:0]          status_reg,
  output logic [CNT_WIDTH-1:0] spike_count
);

  localparam int unsigned TW1 = TS_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state, state_d;
  logic [TS_WIDTH-1:0] cyc, cyc_d;
  logic [TS_WIDTH-1:0] ts_idx, ts_d;
  logic                done_q, done_d;
  logic                aborted_q, aborted_d;
  logic                error_q, error_d;
  logic                start_q, clear_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic                tick_d, nrst_d, donep_d, busy_d;
  logic [31:0]         status_d;

  logic                enable, soft_reset, start_edge, clear_edge, accept;
  logic [TS_WIDTH-1:0] num_ts, period_m1;

  // Control decode and edge detection
  assign enable     = ctrl_reg[0];
  assign soft_reset = ctrl_reg[1];
  assign start_edge = ctrl_reg[2] & ~start_q;
  assign clear_edge = ctrl_reg[3] & ~clear_q;
  assign num_ts     = TS_WIDTH'(config_reg[15:0]);
  assign period_m1  = (config_reg[31:16] == 16'd0) ? '0
                    : TS_WIDTH'(config_reg[31:16]) - TS_WIDTH'(1);

  logic unused_ctrl;
  assign unused_ctrl = ^ctrl_reg[31:4];

  // Next-state, counters and registered-output values
  always_comb begin
    state_d   = state;
    cyc_d     = cyc;
    ts_d      = ts_idx;
    done_d    = done_q;
    aborted_d = aborted_q;
    error_d   = error_q;
    cnt_d     = spike_count;
    nrst_d    = 1'b0;
    donep_d   = 1'b0;
    accept    = 1'b0;

    if (soft_reset) begin
      state_d   = IDLE;
      cyc_d     = '0;
      ts_d      = '0;
      done_d    = 1'b0;
      aborted_d = 1'b0;
      error_d   = 1'b0;
      cnt_d     = '0;
      nrst_d    = 1'b1;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_edge && enable) begin
            if (num_ts != '0) begin
              accept    = 1'b1;
              state_d   = RUN;
              cyc_d     = '0;
              ts_d      = '0;
              done_d    = 1'b0;
              aborted_d = 1'b0;
              error_d   = 1'b0;
              nrst_d    = 1'b1;
            end else begin
              error_d = 1'b1;
            end
          end
        end
        RUN: begin
          if (!enable) begin
            state_d   = IDLE;
            aborted_d = 1'b1;
          end else if (timestep_tick) begin
            cyc_d = '0;
            if (ts_idx < num_ts) ts_d = ts_idx + TS_WIDTH'(1);
            // >= so a num_timesteps lowered mid-run ends the run at this tick
            if ((TW1'(ts_idx) + TW1'(1)) >= TW1'(num_ts)) state_d = DRAIN;
          end else begin
            cyc_d = cyc + TS_WIDTH'(1);
          end
        end
        DRAIN: begin
          if (!enable) begin
            state_d   = IDLE;
            aborted_d = 1'b1;
          end else if (!array_busy) begin
            state_d = DONE;
            done_d  = 1'b1;
            donep_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase

      // Clear (edge or accepted start) wins over a simultaneous spike
      if (clear_edge || accept) begin
        cnt_d = '0;
      end else if (spike_valid && (state == RUN || state == DRAIN) && !(&spike_count)) begin
        cnt_d = spike_count + CNT_WIDTH'(1);
      end
    end

    // Tick is registered, so raise it for the cycle whose cyc reaches period-1;
    // >= keeps a shrunken period from skipping the tick.
    tick_d   = (state_d == RUN) && (cyc_d >= period_m1);
    busy_d   = (state_d == RUN) || (state_d == DRAIN);
    status_d = {16'(ts_d), 8'h00, 2'b00, state_d, error_d, aborted_d, done_d, busy_d};
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cyc           <= '0;
      ts_idx        <= '0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      error_q       <= 1'b0;
      start_q       <= 1'b0;
      clear_q       <= 1'b0;
      timestep_tick <= 1'b0;
      neuron_reset  <= 1'b0;
      done_pulse    <= 1'b0;
      status_reg    <= '0;
      spike_count   <= '0;
    end else begin
      state         <= state_d;
      cyc           <= cyc_d;
      ts_idx        <= ts_d;
      done_q        <= done_d;
      aborted_q     <= aborted_d;
      error_q       <= error_d;
      start_q       <= ctrl_reg[2];
      clear_q       <= ctrl_reg[3];
      timestep_tick <= tick_d;
      neuron_reset  <= nrst_d;
      done_pulse    <= donep_d;
      status_reg    <= status_d;
      spike_count   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_snn_run_controller.sv
// Testbench for snn_run_controller: directed runs with scoreboard queues of expected
// tick/done cycles and timed value checks, consumed by a negedge monitor.
module tb_snn_run_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ctrl_reg, config_reg;
  logic        spike_valid, array_busy;
  logic        timestep_tick, neuron_reset, done_pulse;
  logic [31:0] status_reg, spike_count;
  logic [3:0]  small_count;
  logic        unused_tick, unused_nrst, unused_done;
  logic [31:0] unused_status;

  always #5 clk = ~clk;

  snn_run_controller dut (
    .clk(clk), .rst_n(rst_n), .ctrl_reg(ctrl_reg), .config_reg(config_reg),
    .spike_valid(spike_valid), .array_busy(array_busy),
    .timestep_tick(timestep_tick), .neuron_reset(neuron_reset), .done_pulse(done_pulse),
    .status_reg(status_reg), .spike_count(spike_count)
  );

  // Narrow-counter copy on the same stimulus, for saturation
  snn_run_controller #(.CNT_WIDTH(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .ctrl_reg(ctrl_reg), .config_reg(config_reg),
    .spike_valid(spike_valid), .array_busy(array_busy),
    .timestep_tick(unused_tick), .neuron_reset(unused_nrst), .done_pulse(unused_done),
    .status_reg(unused_status), .spike_count(small_count)
  );

  localparam int K_STATUS = 0, K_COUNT = 1, K_NRST = 2, K_SMALL = 3, K_ZERO = 4;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
  } chk_t;

  chk_t chk_q[$];
  int   tick_q[$];
  int   done_q[$];
  int   cycle = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic exp_chk(input int c, input int kind, input logic [31:0] v);
    chk_t e;
    e.cyc = c; e.kind = kind; e.val = v;
    chk_q.push_back(e);
  endtask

  function automatic string kname(input int k);
    case (k)
      K_STATUS: return "status_reg";
      K_COUNT:  return "spike_count";
      K_NRST:   return "neuron_reset";
      K_SMALL:  return "small_spike_count";
      default:  return "all_outputs_zero";
    endcase
  endfunction

  function automatic logic [31:0] actual_of(input int k);
    case (k)
      K_STATUS: return status_reg;
      K_COUNT:  return spike_count;
      K_NRST:   return {31'b0, neuron_reset};
      K_SMALL:  return 32'(small_count);
      default:  return status_reg | spike_count | {29'b0, timestep_tick, neuron_reset, done_pulse};
    endcase
  endfunction

  // Monitor: compare due value checks and every tick/done pulse against the queues
  logic [31:0] act;
  logic        hit;
  always @(negedge clk) begin
    for (int i = chk_q.size() - 1; i >= 0; i--) begin
      if (chk_q[i].cyc <= cycle) begin
        act = actual_of(chk_q[i].kind);
        n_checks++;
        if (chk_q[i].cyc != cycle || act !== chk_q[i].val) begin
          n_fail++;
          $display("FAIL %s @cycle %0d: got 0x%08h, expected 0x%08h",
                   kname(chk_q[i].kind), chk_q[i].cyc, act, chk_q[i].val);
        end
        chk_q.delete(i);
      end
    end
    hit = 1'b0;
    for (int i = tick_q.size() - 1; i >= 0; i--) begin
      if (tick_q[i] < cycle) begin
        n_checks++; n_fail++;
        $display("FAIL timestep_tick @cycle %0d: got 0, expected 1", tick_q[i]);
        tick_q.delete(i);
      end else if (tick_q[i] == cycle) begin
        hit = 1'b1;
        tick_q.delete(i);
      end
    end
    if (hit || timestep_tick !== 1'b0) begin
      n_checks++;
      if (timestep_tick !== hit) begin
        n_fail++;
        $display("FAIL timestep_tick @cycle %0d: got %b, expected %b", cycle, timestep_tick, hit);
      end
    end
    hit = 1'b0;
    for (int i = done_q.size() - 1; i >= 0; i--) begin
      if (done_q[i] < cycle) begin
        n_checks++; n_fail++;
        $display("FAIL done_pulse @cycle %0d: got 0, expected 1", done_q[i]);
        done_q.delete(i);
      end else if (done_q[i] == cycle) begin
        hit = 1'b1;
        done_q.delete(i);
      end
    end
    if (hit || done_pulse !== 1'b0) begin
      n_checks++;
      if (done_pulse !== hit) begin
        n_fail++;
        $display("FAIL done_pulse @cycle %0d: got %b, expected %b", cycle, done_pulse, hit);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cycle < c) step(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, k2;
    rst_n = 1'b0; ctrl_reg = '0; config_reg = '0; spike_valid = 1'b0; array_busy = 1'b0;
    exp_chk(1, K_ZERO, 0);
    exp_chk(2, K_ZERO, 0);
    exp_chk(2, K_SMALL, 0);
    wait_to(3);
    rst_n = 1'b1;
    exp_chk(5, K_STATUS, 0);
    step(3);

    // Basic run: num=3, period=4
    config_reg = {16'd4, 16'd3}; ctrl_reg = 32'd5; k = cycle;
    exp_chk(k+1, K_STATUS, 32'h0000_0011); exp_chk(k+1, K_NRST, 1); exp_chk(k+2, K_NRST, 0);
    exp_chk(k+5, K_STATUS, 32'h0001_0011); exp_chk(k+13, K_STATUS, 32'h0003_0021);
    exp_chk(k+14, K_STATUS, 32'h0003_0032);
    tick_q.push_back(k+4); tick_q.push_back(k+8); tick_q.push_back(k+12); done_q.push_back(k+14);
    step(1); ctrl_reg = 32'd1;
    wait_to(k+15);

    // Spike counting, clear vs spike, DRAIN counts, DONE does not
    ctrl_reg = 32'd5; k = cycle;
    exp_chk(k+1, K_COUNT, 0); exp_chk(k+7, K_COUNT, 5); exp_chk(k+9, K_COUNT, 5);
    exp_chk(k+10, K_COUNT, 0); exp_chk(k+12, K_COUNT, 1); exp_chk(k+14, K_COUNT, 2);
    exp_chk(k+17, K_COUNT, 2);
    tick_q.push_back(k+4); tick_q.push_back(k+8); tick_q.push_back(k+12); done_q.push_back(k+14);
    step(1); ctrl_reg = 32'd1;
    step(1); spike_valid = 1'b1;
    wait_to(k+7); spike_valid = 1'b0;
    wait_to(k+9); ctrl_reg = 32'd9; spike_valid = 1'b1;
    step(1); ctrl_reg = 32'd1; spike_valid = 1'b0;
    wait_to(k+11); spike_valid = 1'b1;
    step(1); spike_valid = 1'b0;
    wait_to(k+13); spike_valid = 1'b1;
    step(1); spike_valid = 1'b0;
    wait_to(k+15); spike_valid = 1'b1;
    wait_to(k+17); spike_valid = 1'b0;
    wait_to(k+18);

    // Drain held by array_busy
    config_reg = {16'd3, 16'd2}; ctrl_reg = 32'd5; array_busy = 1'b1; k = cycle;
    tick_q.push_back(k+3); tick_q.push_back(k+6); done_q.push_back(k+18);
    exp_chk(k+10, K_STATUS, 32'h0002_0021); exp_chk(k+17, K_STATUS, 32'h0002_0021);
    exp_chk(k+18, K_STATUS, 32'h0002_0032);
    step(1); ctrl_reg = 32'd1;
    wait_to(k+17); array_busy = 1'b0;
    wait_to(k+19);

    // Abort in the 2nd timestep, restart, start during RUN ignored
    config_reg = {16'd3, 16'd4}; ctrl_reg = 32'd5; k = cycle;
    tick_q.push_back(k+3); exp_chk(k+6, K_STATUS, 32'h0001_0004);
    step(1); ctrl_reg = 32'd1;
    wait_to(k+5); ctrl_reg = 32'd0;
    wait_to(k+8); ctrl_reg = 32'd5; k2 = cycle;
    exp_chk(k2+1, K_STATUS, 32'h0000_0011); exp_chk(k2+1, K_NRST, 1);
    exp_chk(k2+4, K_NRST, 0); exp_chk(k2+4, K_STATUS, 32'h0001_0011);
    exp_chk(k2+14, K_STATUS, 32'h0004_0032);
    for (int i = 1; i <= 4; i++) tick_q.push_back(k2 + 3*i);
    done_q.push_back(k2+14);
    step(1); ctrl_reg = 32'd1;
    wait_to(k2+3); ctrl_reg = 32'd5;
    step(1); ctrl_reg = 32'd1;
    wait_to(k2+15);

    // Start with num=0 sets error, state stays DONE; then period=0 ticks every cycle
    config_reg = {16'd3, 16'd0}; ctrl_reg = 32'd5; k = cycle;
    exp_chk(k+1, K_STATUS, 32'h0004_003A); exp_chk(k+1, K_NRST, 0);
    step(1); ctrl_reg = 32'd1;
    step(1);
    config_reg = {16'd0, 16'd3}; ctrl_reg = 32'd5; k = cycle;
    exp_chk(k+1, K_STATUS, 32'h0000_0011); exp_chk(k+5, K_STATUS, 32'h0003_0032);
    tick_q.push_back(k+1); tick_q.push_back(k+2); tick_q.push_back(k+3); done_q.push_back(k+5);
    step(1); ctrl_reg = 32'd1;
    wait_to(k+6);

    // Soft reset mid-run, start ignored while held
    config_reg = {16'd4, 16'd5}; ctrl_reg = 32'd5; k = cycle;
    tick_q.push_back(k+4); exp_chk(k+5, K_COUNT, 2);
    exp_chk(k+7, K_STATUS, 0); exp_chk(k+7, K_COUNT, 0); exp_chk(k+7, K_NRST, 1);
    exp_chk(k+10, K_STATUS, 0); exp_chk(k+10, K_NRST, 1);
    exp_chk(k+12, K_NRST, 0); exp_chk(k+12, K_STATUS, 0);
    step(1); ctrl_reg = 32'd1;
    step(1); spike_valid = 1'b1;
    wait_to(k+4); spike_valid = 1'b0;
    wait_to(k+6); ctrl_reg = 32'd3; spike_valid = 1'b1;
    step(1); spike_valid = 1'b0;
    wait_to(k+8); ctrl_reg = 32'd7;
    step(1); ctrl_reg = 32'd3;
    wait_to(k+11); ctrl_reg = 32'd1;
    wait_to(k+13);

    // Saturation on the 4-bit counter
    config_reg = {16'd40, 16'd1}; ctrl_reg = 32'd5; k = cycle;
    exp_chk(k+16, K_SMALL, 15); exp_chk(k+21, K_SMALL, 15); exp_chk(k+21, K_COUNT, 20);
    tick_q.push_back(k+40); done_q.push_back(k+42);
    step(1); ctrl_reg = 32'd1; spike_valid = 1'b1;
    wait_to(k+21); spike_valid = 1'b0;
    wait_to(k+43);

    // Async reset mid-run; start held high across release counts as an edge
    config_reg = {16'd4, 16'd3}; ctrl_reg = 32'd5; k = cycle;
    tick_q.push_back(k+4); exp_chk(k+5, K_STATUS, 32'h0001_0011);
    exp_chk(k+6, K_ZERO, 0); exp_chk(k+7, K_ZERO, 0);
    exp_chk(k+9, K_STATUS, 32'h0000_0011); exp_chk(k+9, K_NRST, 1);
    exp_chk(k+22, K_STATUS, 32'h0003_0032);
    tick_q.push_back(k+12); tick_q.push_back(k+16); tick_q.push_back(k+20); done_q.push_back(k+22);
    step(1); ctrl_reg = 32'd1;
    wait_to(k+6); rst_n = 1'b0; ctrl_reg = 32'd5;
    wait_to(k+8); rst_n = 1'b1;
    wait_to(k+9); ctrl_reg = 32'd1;
    wait_to(k+24);

    for (int i = 0; i < 100 && (chk_q.size() + tick_q.size() + done_q.size()) != 0; i++) step(1);
    foreach (chk_q[i]) begin
      n_checks++; n_fail++;
      $display("FAIL %s @cycle %0d: got unchecked, expected 0x%08h", kname(chk_q[i].kind), chk_q[i].cyc, chk_q[i].val);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/snn_run_controller.md
# snn_run_controller

Run sequencer between the AXI-Lite register file and the neuron array. Decodes the control and config words written by software, sequences a run of N timesteps of programmable length, and issues timestep ticks and neuron resets to the array. Counts output spikes and returns the status and spike-count words that the register file exposes for readback.

## Interface
- TS_WIDTH, 16, width of timestep count and cycles-per-timestep fields
- CNT_WIDTH, 32, width of the spike counter
- clk  in  1  single clock for the block; same clock as the register file
- rst_n  in  1  reset, asynchronous, active-low
- ctrl_reg  in  32  control word: bit0 enable (level), bit1 soft_reset (level), bit2 start (rising edge), bit3 clear_count (rising edge); other bits ignored
- config_reg  in  32  [15:0] num_timesteps, [31:16] cycles_per_timestep
- spike_valid  in  1  one output spike from the array this cycle
- array_busy  in  1  array still processing in-flight events
- timestep_tick  out  1  one-cycle pulse at the end of each timestep
- neuron_reset  out  1  clears neuron state in the array
- done_pulse  out  1  one-cycle pulse on run completion (interrupt source)
- status_reg  out  32  status word, see Operation
- spike_count  out  CNT_WIDTH  spikes counted since the last clear

## Operation
- States: IDLE(0), RUN(1), DRAIN(2), DONE(3).
- Edge detect: start_q and clear_q register ctrl_reg[2] and ctrl_reg[3]. start_edge = ctrl_reg[2] & ~start_q. clear_edge is formed the same way from ctrl_reg[3].
- IDLE/DONE + start_edge + enable:
  - num_timesteps != 0: go to RUN. Clear cyc, ts_idx, spike_count, done, aborted and error. neuron_reset pulses 1 cycle.
  - num_timesteps == 0: stay in the current state and set error.
- start_edge with enable=0, or start_edge while in RUN/DRAIN: ignored.
- RUN: cyc increments every cycle. period = cycles_per_timestep, with 0 treated as 1.
  - cyc == period-1: timestep_tick=1, cyc←0, ts_idx+1.
  - The tick for ts_idx == num_timesteps-1 moves the FSM to DRAIN.
- config_reg is sampled every cycle. Changes during a run take effect immediately. A new num_timesteps ≤ ts_idx ends the run at the next tick.
- DRAIN: wait for array_busy==0, then go to DONE. done_pulse=1 for 1 cycle and done bit set.
- DONE: behaves as IDLE for starts. done, aborted and error are sticky until the next accepted start or a soft reset.
- enable=0 in RUN or DRAIN: go to IDLE next cycle and set aborted. No done_pulse.
- soft_reset level high, any state: FSM forced to IDLE. cyc, ts_idx, spike_count and all sticky bits cleared. neuron_reset held high. Start edges are ignored. soft_reset has priority over every other event.
- spike_count:
  - Increments on spike_valid in RUN or DRAIN only.
  - Saturates at all-ones.
  - Cleared by clear_edge, accepted start or soft_reset. Clear wins over a simultaneous spike (result 0).
- status_reg:
  - [0] busy = RUN|DRAIN
  - [1] done
  - [2] aborted
  - [3] error
  - [5:4] state
  - [7:6] 0
  - [15:8] 0
  - [31:16] ts_idx

## Timing
- All outputs are registered.
- Reset values: state IDLE. All outputs 0, except status_reg=0 and spike_count=0. start_q=clear_q=0, so a ctrl_reg[2] already high at reset release counts as an edge.
- Start latency: start_edge seen in cycle k gives state=RUN, busy=1 and neuron_reset=1 in cycle k+1. The first RUN cycle is k+1 with cyc=0.
- Tick timing: first timestep_tick in cycle k+period, then every period cycles. RUN lasts exactly num_timesteps×period cycles. DRAIN is entered the cycle after the final tick.
- DRAIN→DONE: if array_busy==0 on the DRAIN-entry cycle, done_pulse occurs 1 cycle later.
- spike_count reflects spike_valid with 1-cycle latency.
- Asynchronous reset mid-run: all state returns to reset values immediately. No done_pulse.
- ts_idx wraps only through a new start. It never exceeds num_timesteps.

## Test plan
- Basic run: enable=1, num=3, period=4, start edge at k → ticks at k+4/8/12; array_busy=0 → done_pulse at k+14; status_reg=0x0003_0032 (ts_idx=3, DONE, done=1).
- Spike counting: 5 spike_valid pulses during RUN plus 2 in IDLE → spike_count=5. clear_edge coinciding with a spike → spike_count=0. Force count to 0xFFFF_FFFF, then add a spike → stays 0xFFFF_FFFF.
- Drain: hold array_busy=1 for 10 cycles after the last tick → state stays DRAIN (status[5:4]=2, busy=1), done_pulse one cycle after array_busy falls.
- Abort: drop enable at the 2nd timestep → IDLE next cycle, status[2]=1, no done_pulse; a new start clears aborted.
- Errors and ignores: start with num=0 → error=1, state unchanged. Start while in RUN → ignored. period=0 → tick every cycle.
- Soft reset and async reset: soft_reset high mid-RUN → neuron_reset high, status=0, spike_count=0, start ignored while held. rst_n low mid-RUN → all outputs 0 immediately.
